// File: rtl/decoder_pkg.sv
// Shared decode/fetch types; pc_gen_state_t encodes the fetch PC generator FSM.
package decoder_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HOLD = 2'd2
    } pc_gen_state_t;

endpackage

// File: rtl/pc_prio_sel.sv
// Combinational redirect priority encoder and target mux for pc_gen.
// Index 0 wins; the chosen target is also returned with its low log2(Step) bits cleared.
module pc_prio_sel
    import decoder_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int NumTargets = 4,
    parameter int Step       = 4,
    parameter int SelWidth   = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
    input  logic [NumTargets-1:0]           redirect,
    input  logic [NumTargets*AddrWidth-1:0] target,
    output logic                            any,
    output logic [SelWidth-1:0]             sel,
    output logic [AddrWidth-1:0]            raw_target,
    output logic [AddrWidth-1:0]            aligned_target
);

    localparam logic [AddrWidth-1:0] LowMask = AddrWidth'(Step - 1);

    // Scanning from the top down lets the lowest active index overwrite the result last.
    always_comb begin
        any        = 1'b0;
        sel        = '0;
        raw_target = '0;
        for (int i = NumTargets - 1; i >= 0; i--) begin
            if (redirect[i]) begin
                any        = 1'b1;
                sel        = SelWidth'(i);
                raw_target = target[i*AddrWidth +: AddrWidth];
            end
        end
    end

    assign aligned_target = raw_target & ~LowMask;

endmodule

// File: rtl/pc_gen.sv
// Registered fetch PC generator: sequential stepping, prioritised redirects, stall-safe pending redirect.
// Optional macro PC_MISALIGN_CHECK_EN adds a registered misaligned-target report.
module pc_gen
    import decoder_pkg::*;
#(
    parameter int                   AddrWidth  = 32,
    parameter int                   NumTargets = 4,
    parameter int                   Step       = 4,
    parameter logic [AddrWidth-1:0] ResetAddr  = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            stall,
    input  logic [NumTargets-1:0]           redirect,
    input  logic [NumTargets*AddrWidth-1:0] target,
    output logic [AddrWidth-1:0]            pc_o,
    output logic                            pc_valid_o,
    output logic                            flush_o
`ifdef PC_MISALIGN_CHECK_EN
   ,output logic                            misalign_o,
    output logic [AddrWidth-1:0]            misalign_addr_o
`endif
);

    localparam int SelWidth = (NumTargets > 1) ? $clog2(NumTargets) : 1;

    pc_gen_state_t          state;
    logic [AddrWidth-1:0]   pend;
    logic                   any;
    logic [SelWidth-1:0]    sel;
    logic [AddrWidth-1:0]   raw_target;
    logic [AddrWidth-1:0]   aligned_target;

    pc_prio_sel #(
        .AddrWidth  (AddrWidth),
        .NumTargets (NumTargets),
        .Step       (Step),
        .SelWidth   (SelWidth)
    ) u_prio_sel (
        .redirect       (redirect),
        .target         (target),
        .any            (any),
        .sel            (sel),
        .raw_target     (raw_target),
        .aligned_target (aligned_target)
    );

    // A redirect seen while stalled parks in pend; a fresh redirect at release beats it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PC_BOOT;
            pc_o       <= ResetAddr;
            pc_valid_o <= 1'b0;
            flush_o    <= 1'b0;
            pend       <= '0;
        end else begin
            flush_o <= 1'b0;
            case (state)
                PC_BOOT: begin
                    state      <= PC_RUN;
                    pc_valid_o <= 1'b1;
                end
                PC_RUN: begin
                    if (any) begin
                        if (stall) begin
                            pend  <= aligned_target;
                            state <= PC_HOLD;
                        end else begin
                            pc_o    <= aligned_target;
                            flush_o <= 1'b1;
                        end
                    end else if (!stall) begin
                        pc_o <= pc_o + AddrWidth'(Step);
                    end
                end
                PC_HOLD: begin
                    if (stall) begin
                        if (any) begin
                            pend <= aligned_target;
                        end
                    end else begin
                        pc_o    <= any ? aligned_target : pend;
                        flush_o <= 1'b1;
                        state   <= PC_RUN;
                    end
                end
                default: state <= PC_BOOT;
            endcase
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    localparam logic [AddrWidth-1:0] LowMask = AddrWidth'(Step - 1);

    // Flag every target the FSM actually consumes (captured or applied) whose low bits were set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= 1'b0;
            if ((state != PC_BOOT) && any && ((raw_target & LowMask) != '0)) begin
                misalign_o      <= 1'b1;
                misalign_addr_o <= raw_target;
            end
        end
    end

    logic unused_sel;
    assign unused_sel = ^sel;
`else
    logic unused_sel;
    assign unused_sel = ^{sel, raw_target};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, reset-in-HOLD sequence, random run vs. model.
// Define PC_MISALIGN_CHECK_EN to also check the misalignment report.
module tb_pc_gen;

    localparam int STEP = 4;

    logic         clk;
    logic         reset_n;
    logic         stall;
    logic [3:0]   redirect;
    logic [127:0] target;
    logic [31:0]  pc_o;
    logic         pc_valid_o;
    logic         flush_o;
`ifdef PC_MISALIGN_CHECK_EN
    logic         misalign_o;
    logic [31:0]  misalign_addr_o;
`endif

    int checks = 0;
    int errors = 0;

    pc_gen #(
        .AddrWidth  (32),
        .NumTargets (4),
        .Step       (STEP),
        .ResetAddr  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect        (redirect),
        .target          (target),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .flush_o         (flush_o)
`ifdef PC_MISALIGN_CHECK_EN
       ,.misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         stall;
        logic [3:0]   redirect;
        logic [127:0] target;
        logic [31:0]  exp_pc;
        logic         exp_flush;
        logic         exp_valid;
        logic         exp_mis;
    } vec_t;

    vec_t vecs [21];

    // Behavioural reference: booted flag, PC, optional pending target.
    logic        m_booted;
    logic        m_valid;
    logic        m_flush;
    logic [31:0] m_pc;
    logic        m_has_pend;
    logic [31:0] m_pend;
    logic        m_mis;
    logic [31:0] m_mis_addr;

    function automatic logic [127:0] pack4(input logic [31:0] t0, input logic [31:0] t1,
                                           input logic [31:0] t2, input logic [31:0] t3);
        return {t3, t2, t1, t0};
    endfunction

    function automatic vec_t mk(input logic s, input logic [3:0] r, input logic [127:0] t,
                                input logic [31:0] p, input logic f, input logic v, input logic m);
        vec_t x;
        x.stall     = s;
        x.redirect  = r;
        x.target    = t;
        x.exp_pc    = p;
        x.exp_flush = f;
        x.exp_valid = v;
        x.exp_mis   = m;
        return x;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [3:0] r, input logic [127:0] t);
        stall    = s;
        redirect = r;
        target   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_booted   = 1'b0;
        m_valid    = 1'b0;
        m_flush    = 1'b0;
        m_pc       = 32'h0;
        m_has_pend = 1'b0;
        m_pend     = 32'h0;
        m_mis      = 1'b0;
        m_mis_addr = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic [3:0] r, input logic [127:0] t);
        int          hit;
        logic [31:0] raw;
        logic [31:0] al;
        hit     = -1;
        raw     = 32'h0;
        al      = 32'h0;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        for (int i = 3; i >= 0; i--) if (r[i]) hit = i;
        if (!m_booted) begin
            m_booted = 1'b1;
            m_valid  = 1'b1;
        end else begin
            if (hit >= 0) begin
                raw = t[hit*32 +: 32];
                al  = raw - (raw % STEP);
                if ((raw % STEP) != 0) begin
                    m_mis      = 1'b1;
                    m_mis_addr = raw;
                end
            end
            if (s) begin
                if (hit >= 0) begin
                    m_pend     = al;
                    m_has_pend = 1'b1;
                end
            end else if (hit >= 0) begin
                m_pc       = al;
                m_flush    = 1'b1;
                m_has_pend = 1'b0;
            end else if (m_has_pend) begin
                m_pc       = m_pend;
                m_flush    = 1'b1;
                m_has_pend = 1'b0;
            end else begin
                m_pc = m_pc + 32'(STEP);
            end
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        stall    = 1'b0;
        redirect = 4'b0;
        target   = '0;
        #3;
        check_output("reset_pc", pc_o, 32'h0);
        check_output("reset_valid", {31'b0, pc_valid_o}, 32'h0);
        check_output("reset_flush", {31'b0, flush_o}, 32'h0);
`ifdef PC_MISALIGN_CHECK_EN
        check_output("reset_misalign", {31'b0, misalign_o}, 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(1, 4'b0001, pack4(32'h702, 0, 0, 0),           32'h0,        0, 1, 0);
        vecs[1]  = mk(0, 4'b0000, '0,                                32'h4,        0, 1, 0);
        vecs[2]  = mk(0, 4'b0000, '0,                                32'h8,        0, 1, 0);
        vecs[3]  = mk(0, 4'b0000, '0,                                32'hC,        0, 1, 0);
        vecs[4]  = mk(0, 4'b0110, pack4(0, 32'h100, 32'h200, 0),     32'h100,      1, 1, 0);
        vecs[5]  = mk(0, 4'b0000, '0,                                32'h104,      0, 1, 0);
        vecs[6]  = mk(1, 4'b0001, pack4(32'h40, 0, 0, 0),            32'h104,      0, 1, 0);
        vecs[7]  = mk(1, 4'b0000, '0,                                32'h104,      0, 1, 0);
        vecs[8]  = mk(1, 4'b0000, '0,                                32'h104,      0, 1, 0);
        vecs[9]  = mk(0, 4'b0000, '0,                                32'h40,       1, 1, 0);
        vecs[10] = mk(1, 4'b0001, pack4(32'h40, 0, 0, 0),            32'h40,       0, 1, 0);
        vecs[11] = mk(1, 4'b1000, pack4(0, 0, 0, 32'h80),            32'h40,       0, 1, 0);
        vecs[12] = mk(0, 4'b0000, '0,                                32'h80,       1, 1, 0);
        vecs[13] = mk(0, 4'b0000, '0,                                32'h84,       0, 1, 0);
        vecs[14] = mk(0, 4'b0001, pack4(32'h102, 0, 0, 0),           32'h100,      1, 1, 1);
        vecs[15] = mk(0, 4'b0011, pack4(32'h10, 32'h20, 0, 0),       32'h10,       1, 1, 0);
        vecs[16] = mk(1, 4'b0100, pack4(0, 0, 32'h300, 0),           32'h10,       0, 1, 0);
        vecs[17] = mk(0, 4'b0010, pack4(0, 32'h500, 0, 0),           32'h500,      1, 1, 0);
        vecs[18] = mk(0, 4'b0001, pack4(32'hFFFF_FFFC, 0, 0, 0),     32'hFFFF_FFFC, 1, 1, 0);
        vecs[19] = mk(0, 4'b0000, '0,                                32'h0,        0, 1, 0);
        vecs[20] = mk(0, 4'b0000, '0,                                32'h4,        0, 1, 0);

        do_reset();

        for (int k = 0; k < 21; k++) begin
            apply_stimulus(vecs[k].stall, vecs[k].redirect, vecs[k].target);
            check_output($sformatf("vec%0d_pc", k), pc_o, vecs[k].exp_pc);
            check_output($sformatf("vec%0d_flush", k), {31'b0, flush_o}, {31'b0, vecs[k].exp_flush});
            check_output($sformatf("vec%0d_valid", k), {31'b0, pc_valid_o}, {31'b0, vecs[k].exp_valid});
`ifdef PC_MISALIGN_CHECK_EN
            check_output($sformatf("vec%0d_mis", k), {31'b0, misalign_o}, {31'b0, vecs[k].exp_mis});
            if (vecs[k].exp_mis)
                check_output($sformatf("vec%0d_mis_addr", k), misalign_addr_o, 32'h102);
`endif
        end

        // Reset asserted while a redirect is parked: PC returns at once, pending target is lost.
        apply_stimulus(1, 4'b0001, pack4(32'h240, 0, 0, 0));
        check_output("hold_pc", pc_o, 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midreset_pc", pc_o, 32'h0);
        check_output("midreset_valid", {31'b0, pc_valid_o}, 32'h0);
        check_output("midreset_flush", {31'b0, flush_o}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_stimulus(0, 4'b0000, '0);
        check_output("reboot_pc", pc_o, 32'h0);
        check_output("reboot_valid", {31'b0, pc_valid_o}, 32'h1);
        apply_stimulus(0, 4'b0000, '0);
        check_output("after_reboot_pc", pc_o, 32'h4);
        check_output("after_reboot_flush", {31'b0, flush_o}, 32'h0);

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic         s;
            logic [3:0]   r;
            logic [127:0] t;
            s = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            t = {$urandom, $urandom, $urandom, $urandom};
            apply_stimulus(s, r, t);
            model_step(s, r, t);
            check_output("rand_pc", pc_o, m_pc);
            check_output("rand_flush", {31'b0, flush_o}, {31'b0, m_flush});
            check_output("rand_valid", {31'b0, pc_valid_o}, {31'b0, m_valid});
`ifdef PC_MISALIGN_CHECK_EN
            check_output("rand_mis", {31'b0, misalign_o}, {31'b0, m_mis});
            if (m_mis)
                check_output("rand_mis_addr", misalign_addr_o, m_mis_addr);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
